// File: rtl/load_store_unit.sv
// Load/store front end: word-only mem access with sub-word RMW stores and extended loads.
// Latency accept->resp_valid: error 1, load 2, store 3; one op in flight, resp held until resp_ready.
module load_store_unit #(
    parameter int RAM_SIZE_LOG = 8,
    parameter bit CHECK_RANGE  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_ra,
    input  logic [31:0] mem_rd,
    output logic        mem_we,
    output logic [31:0] mem_wa,
    output logic [2:0]  mem_wm,
    output logic [31:0] mem_wd
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [2:0] MODE_BYTE  = 3'b000;
    localparam logic [2:0] MODE_HALF  = 3'b001;
    localparam logic [2:0] MODE_WORD  = 3'b010;
    localparam logic [2:0] MODE_UBYTE = 3'b100;
    localparam logic [2:0] MODE_UHALF = 3'b101;

    state_t      state_q;
    logic        we_q;
    logic [2:0]  mode_q;
    logic [1:0]  addr_q;
    logic [31:0] wdata_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic [31:0] mem_ra_q;
    logic        mem_we_q;
    logic [31:0] mem_wa_q;
    logic [31:0] mem_wd_q;

    logic        req_err;
    logic [31:0] load_d;
    logic [31:0] merge_d;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        req_err = 1'b0;
        case (req_mode)
            MODE_BYTE:  req_err = 1'b0;
            MODE_HALF:  req_err = req_addr[0];
            MODE_WORD:  req_err = (req_addr[1:0] != 2'b00);
            MODE_UBYTE: req_err = req_we;
            MODE_UHALF: req_err = req_we | req_addr[0];
            default:    req_err = 1'b1;
        endcase
        if (CHECK_RANGE && ((req_addr >> (RAM_SIZE_LOG + 2)) != 32'd0)) begin
            req_err = 1'b1;
        end
    end

    assign rd_byte = mem_rd[{addr_q, 3'b000} +: 8];
    assign rd_half = mem_rd[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_d = 32'd0;
        case (mode_q)
            MODE_BYTE:  load_d = {{24{rd_byte[7]}}, rd_byte};
            MODE_HALF:  load_d = {{16{rd_half[15]}}, rd_half};
            MODE_WORD:  load_d = mem_rd;
            MODE_UBYTE: load_d = {24'd0, rd_byte};
            MODE_UHALF: load_d = {16'd0, rd_half};
            default:    load_d = 32'd0;
        endcase
    end

    // Lanes not addressed by the store keep the word just read.
    always_comb begin
        merge_d = mem_rd;
        case (mode_q)
            MODE_BYTE, MODE_UBYTE: merge_d[{addr_q, 3'b000} +: 8]       = wdata_q[7:0];
            MODE_HALF, MODE_UHALF: merge_d[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
            MODE_WORD:             merge_d = wdata_q;
            default:               merge_d = mem_rd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            mode_q       <= 3'd0;
            addr_q       <= 2'd0;
            wdata_q      <= 32'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            mem_ra_q     <= 32'd0;
            mem_we_q     <= 1'b0;
            mem_wa_q     <= 32'd0;
            mem_wd_q     <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        mode_q      <= req_mode;
                        addr_q      <= req_addr[1:0];
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (req_err) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'd0;
                            state_q      <= RESP;
                        end else begin
                            mem_ra_q <= {req_addr[31:2], 2'b00};
                            state_q  <= READ;
                        end
                    end
                end
                READ: begin
                    if (we_q) begin
                        mem_we_q <= 1'b1;
                        mem_wa_q <= mem_ra_q;
                        mem_wd_q <= merge_d;
                        state_q  <= WRITE;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_d;
                        state_q      <= RESP;
                    end
                end
                WRITE: begin
                    mem_we_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'd0;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_ra     = mem_ra_q;
    // mem writes on the negedge inside WRITE, so reset must squash the pending strobe at once.
    assign mem_we     = mem_we_q & ~reset;
    assign mem_wa     = mem_wa_q;
    assign mem_wm     = MODE_WORD;
    assign mem_wd     = mem_wd_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table with an expected-response queue, plus reset/backpressure sequences.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_mode;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_ra, mem_rd, mem_wa, mem_wd;
    logic        mem_we;
    logic [2:0]  mem_wm;

    always #5 clk = ~clk;

    load_store_unit #(.RAM_SIZE_LOG(8), .CHECK_RANGE(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_ra(mem_ra), .mem_rd(mem_rd), .mem_we(mem_we),
        .mem_wa(mem_wa), .mem_wm(mem_wm), .mem_wd(mem_wd)
    );

    // Memory model: combinational read, negedge write; preset port lets the test seed words.
    logic [31:0] dmem [256];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_idx = 8'd0;
    logic [31:0] pre_dat = 32'd0;
    int          we_cnt = 0;
    logic [31:0] last_wa = 32'd0;
    logic [2:0]  last_wm = 3'd0;

    assign mem_rd = dmem[mem_ra[9:2]];

    always @(negedge clk) begin
        if (pre_en) dmem[pre_idx] = pre_dat;
        if (mem_we) begin
            dmem[mem_wa[9:2]] = mem_wd;
            last_wa = mem_wa;
            last_wm = mem_wm;
            we_cnt  = we_cnt + 1;
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pre;
        logic [31:0] init;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_word;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic we, logic [2:0] mode, logic [31:0] addr, logic [31:0] wdata,
                                logic pre, logic [31:0] init, logic [31:0] rd, logic err,
                                int lat, logic [31:0] word);
        vec_t v;
        v.we = we; v.mode = mode; v.addr = addr; v.wdata = wdata; v.pre = pre; v.init = init;
        v.exp_rdata = rd; v.exp_err = err; v.exp_lat = lat; v.exp_word = word;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preset(input logic [7:0] idx, input logic [31:0] dat);
        pre_en = 1'b1; pre_idx = idx; pre_dat = dat;
        @(negedge clk); #1;
        pre_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        exp_t        e;
        int          lat;
        int          w0;
        logic [31:0] ra_mid;
        string       tag;
        tag = $sformatf("v%0d", k);
        if (v.pre) preset(v.addr[9:2], v.init);
        w0 = we_cnt;
        req_valid = 1'b1; req_we = v.we; req_mode = v.mode; req_addr = v.addr; req_wdata = v.wdata;
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
        sb.push_back(e);
        @(posedge clk); #1;
        // Inputs change mid-op; the latched request must be used.
        req_we = ~v.we; req_mode = 3'b010; req_addr = 32'h0000_0044; req_wdata = 32'h0;
        check({tag, " req_ready busy"}, {31'd0, req_ready}, 32'd0);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        ra_mid = last_wa;
        e = sb.pop_front();
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " rdata"}, resp_rdata, e.rdata);
        check({tag, " err"}, {31'd0, resp_err}, {31'd0, e.err});
        check({tag, " writes"}, 32'(we_cnt - w0), (v.we && !v.exp_err) ? 32'd1 : 32'd0);
        if (v.we && !v.exp_err) begin
            check({tag, " mem_wa"}, ra_mid, {v.addr[31:2], 2'b00});
            check({tag, " mem_wm"}, {29'd0, last_wm}, 32'd2);
        end
        check({tag, " word"}, dmem[v.addr[9:2]], v.exp_word);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, " req_ready idle"}, {31'd0, req_ready}, 32'd1);
        check({tag, " resp_valid idle"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        int lat;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_mode = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;

        // v1..v9: sub-word loads (test words 0x11223344 and 0x80FF7F01 at index 5)
        vecs.push_back(mk(0, 3'b000, 32'h17, 0, 1, 32'h11223344, 32'h00000011, 0, 2, 32'h11223344));
        vecs.push_back(mk(0, 3'b001, 32'h16, 0, 1, 32'h80FF7F01, 32'hFFFF80FF, 0, 2, 32'h80FF7F01));
        vecs.push_back(mk(0, 3'b101, 32'h16, 0, 0, 0, 32'h000080FF, 0, 2, 32'h80FF7F01));
        vecs.push_back(mk(0, 3'b000, 32'h14, 0, 0, 0, 32'h00000001, 0, 2, 32'h80FF7F01));
        vecs.push_back(mk(0, 3'b000, 32'h15, 0, 0, 0, 32'h0000007F, 0, 2, 32'h80FF7F01));
        vecs.push_back(mk(0, 3'b000, 32'h16, 0, 0, 0, 32'hFFFFFFFF, 0, 2, 32'h80FF7F01));
        vecs.push_back(mk(0, 3'b100, 32'h17, 0, 0, 0, 32'h00000080, 0, 2, 32'h80FF7F01));
        vecs.push_back(mk(0, 3'b001, 32'h14, 0, 0, 0, 32'h00007F01, 0, 2, 32'h80FF7F01));
        vecs.push_back(mk(0, 3'b010, 32'h14, 0, 0, 0, 32'h80FF7F01, 0, 2, 32'h80FF7F01));
        // stores with read-modify-write, then read-back
        vecs.push_back(mk(1, 3'b000, 32'h15, 32'hFFFFFFAB, 1, 32'h11223344, 0, 0, 3, 32'h1122AB44));
        vecs.push_back(mk(1, 3'b001, 32'h16, 32'h1234BEEF, 1, 32'h11223344, 0, 0, 3, 32'hBEEF3344));
        vecs.push_back(mk(0, 3'b010, 32'h14, 0, 0, 0, 32'hBEEF3344, 0, 2, 32'hBEEF3344));
        vecs.push_back(mk(1, 3'b010, 32'h20, 32'hDEADBEEF, 1, 32'h0, 0, 0, 3, 32'hDEADBEEF));
        vecs.push_back(mk(1, 3'b000, 32'h23, 32'h0000005A, 0, 0, 0, 0, 3, 32'h5AADBEEF));
        vecs.push_back(mk(0, 3'b000, 32'h21, 0, 0, 0, 32'hFFFFFFBE, 0, 2, 32'h5AADBEEF));
        vecs.push_back(mk(1, 3'b001, 32'h20, 32'hFFFF0102, 0, 0, 0, 0, 3, 32'h5AAD0102));
        vecs.push_back(mk(0, 3'b010, 32'h20, 0, 0, 0, 32'h5AAD0102, 0, 2, 32'h5AAD0102));
        vecs.push_back(mk(0, 3'b010, 32'h3FC, 0, 1, 32'h01234567, 32'h01234567, 0, 2, 32'h01234567));
        // errors: no memory access, rdata 0, latency 1
        vecs.push_back(mk(0, 3'b010, 32'h13, 0, 1, 32'hCAFEF00D, 0, 1, 1, 32'hCAFEF00D));
        vecs.push_back(mk(0, 3'b001, 32'h15, 0, 1, 32'hCAFEF00D, 0, 1, 1, 32'hCAFEF00D));
        vecs.push_back(mk(0, 3'b011, 32'h14, 0, 0, 0, 0, 1, 1, 32'hCAFEF00D));
        vecs.push_back(mk(1, 3'b100, 32'h14, 32'h55, 0, 0, 0, 1, 1, 32'hCAFEF00D));
        vecs.push_back(mk(1, 3'b101, 32'h16, 32'h5555, 0, 0, 0, 1, 1, 32'hCAFEF00D));
        vecs.push_back(mk(1, 3'b110, 32'h14, 32'h55, 0, 0, 0, 1, 1, 32'hCAFEF00D));
        vecs.push_back(mk(0, 3'b111, 32'h14, 0, 0, 0, 0, 1, 1, 32'hCAFEF00D));
        vecs.push_back(mk(0, 3'b101, 32'h17, 0, 0, 0, 0, 1, 1, 32'hCAFEF00D));
        vecs.push_back(mk(0, 3'b010, 32'h400, 0, 1, 32'hCAFEF00D, 0, 1, 1, 32'hCAFEF00D));
        vecs.push_back(mk(1, 3'b010, 32'h10000014, 32'h1, 1, 32'hCAFEF00D, 0, 1, 1, 32'hCAFEF00D));

        repeat (3) @(posedge clk);
        #1;
        check("rst req_ready", {31'd0, req_ready}, 32'd1);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        check("rst resp_err", {31'd0, resp_err}, 32'd0);
        check("rst mem_we", {31'd0, mem_we}, 32'd0);
        check("rst mem_ra", mem_ra, 32'd0);
        check("rst mem_wa", mem_wa, 32'd0);
        check("rst mem_wd", mem_wd, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i + 1);

        // Reset while in WRITE: the pending write must never reach memory.
        preset(8'd8, 32'h01020304);
        w0 = we_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_mode = 3'b000; req_addr = 32'h20; req_wdata = 32'hEE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("wr_rst mem_we in WRITE", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("wr_rst mem_we squashed", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("wr_rst mem_we after", {31'd0, mem_we}, 32'd0);
        check("wr_rst req_ready", {31'd0, req_ready}, 32'd1);
        check("wr_rst resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        check("wr_rst dmem", dmem[8], 32'h01020304);
        check("wr_rst writes", 32'(we_cnt - w0), 32'd0);
        check("wr_rst still idle", {31'd0, req_ready}, 32'd1);

        // Backpressure: response held stable while resp_ready stays low.
        preset(8'd9, 32'h89ABCDEF);
        req_valid = 1'b1; req_we = 1'b0; req_mode = 3'b001; req_addr = 32'h26; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("hold latency", 32'(lat), 32'd2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d resp_valid", c), {31'd0, resp_valid}, 32'd1);
            check($sformatf("hold%0d rdata", c), resp_rdata, 32'hFFFF89AB);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("hold released", {31'd0, resp_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
